// File: rtl/trng_read_buffer.sv
// trng_read_buffer: consumer-side buffer for trng_core output.
// Captures single-cycle word strobes into a DEPTH-entry FIFO of {range, raw}
// pairs while health_ok is high, and serves them through a req/ack read port
// with a bounded wait. Overflow is reported as a sticky flag.
// Optional feature macro: TRNG_RDBUF_DUP_CHECK_EN enables a repeated-word
// check on in_raw (continuous random number test) driving dup_fail.
// Read handshake: rd_req/rd_sel are sampled only while the FSM is IDLE;
// rd_ack is high for exactly one cycle and rd_data/rd_err are valid only
// during that cycle. Requests made while a read is in flight are dropped.
module trng_read_buffer #(
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                     clk,
   input  logic                     aresetn,
   input  logic                     in_valid,
   input  logic [31:0]              in_raw,
   input  logic [31:0]              in_range,
   input  logic                     health_ok,
   input  logic                     flush,
   input  logic                     rd_req,
   input  logic                     rd_sel,
   output logic                     rd_ack,
   output logic [31:0]              rd_data,
   output logic                     rd_err,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic                     dup_fail,
   output logic [1:0]               dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] T_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [63:0]   mem [DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic [63:0]   head;
   logic [TW-1:0] timer_q;
   logic          sel_q;
   logic          data_sel;
   logic          pop, load_data, load_timeout, timer_inc, timer_clr, sel_cap;
   logic          cand, push, drop, dup_hit;

   // Occupancy comes straight from the pointer registers (wrap bit included).
   assign level     = wr_ptr - rd_ptr;
   assign full      = (level == DEPTH_L);
   assign empty     = (level == '0);
   assign head      = mem[rd_ptr[AW-1:0]];
   assign dbg_state = state_q;
   assign data_sel  = (state_q == S_IDLE) ? rd_sel : sel_q;

   // A word is a write candidate when strobed under good health and no flush.
   assign cand = in_valid && health_ok && !flush;
   assign push = cand && (!full || pop) && !dup_hit;
   assign drop = cand && full && !pop;

   // FSM state register.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // FSM next state and read-path control strobes; flush blocks any pop.
   always_comb begin
      state_d      = state_q;
      pop          = 1'b0;
      load_data    = 1'b0;
      load_timeout = 1'b0;
      timer_inc    = 1'b0;
      timer_clr    = 1'b0;
      sel_cap      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rd_req) begin
               if (!empty && !flush) begin
                  pop       = 1'b1;
                  load_data = 1'b1;
                  state_d   = S_ACK;
               end else begin
                  timer_clr = 1'b1;
                  sel_cap   = 1'b1;
                  state_d   = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!empty && !flush) begin
               pop       = 1'b1;
               load_data = 1'b1;
               state_d   = S_ACK;
            end else if ((TIMEOUT_CYCLES != 0) && (timer_q == T_LAST)) begin
               load_timeout = 1'b1;
               state_d      = S_ACK;
            end else begin
               timer_inc = 1'b1;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO pointers; flush rewinds both and wins over push/pop.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // FIFO storage; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {in_range, in_raw};
   end

   // Sticky overflow flag.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)  overflow <= 1'b0;
      else if (flush) overflow <= 1'b0;
      else if (drop)  overflow <= 1'b1;
   end

   // Read response registers, wait timer and latched half-select.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         rd_ack  <= 1'b0;
         rd_data <= '0;
         rd_err  <= 1'b0;
         timer_q <= '0;
         sel_q   <= 1'b0;
      end else begin
         rd_ack <= (state_d == S_ACK);
         if (load_data) begin
            rd_data <= data_sel ? head[63:32] : head[31:0];
            rd_err  <= 1'b0;
         end else if (load_timeout) begin
            rd_data <= '0;
            rd_err  <= 1'b1;
         end
         if (timer_clr)      timer_q <= '0;
         else if (timer_inc) timer_q <= timer_q + 1'b1;
         if (sel_cap) sel_q <= rd_sel;
      end
   end

`ifdef TRNG_RDBUF_DUP_CHECK_EN
   logic [31:0] ref_raw;
   logic        ref_valid;

   assign dup_hit = ref_valid && (in_raw == ref_raw);

   // Reference word tracks the last accepted in_raw; repeats are rejected.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         ref_raw   <= '0;
         ref_valid <= 1'b0;
         dup_fail  <= 1'b0;
      end else if (flush) begin
         ref_valid <= 1'b0;
         dup_fail  <= 1'b0;
      end else begin
         if (push) begin
            ref_raw   <= in_raw;
            ref_valid <= 1'b1;
         end
         if (cand && dup_hit) dup_fail <= 1'b1;
      end
   end
`else
   assign dup_hit  = 1'b0;
   assign dup_fail = 1'b0;
`endif

endmodule

// File: tb/tb_trng_read_buffer.sv
// Testbench for trng_read_buffer: directed scenarios with literal expectations
// followed by a randomized phase, all checked cycle by cycle against a
// queue-based reference model.
module tb_trng_read_buffer;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 16;
   localparam int LW      = $clog2(DEPTH) + 1;
`ifdef TRNG_RDBUF_DUP_CHECK_EN
   localparam bit DUP_EN = 1'b1;
`else
   localparam bit DUP_EN = 1'b0;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic aresetn = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid = 1'b0;
   logic [31:0]   in_raw = '0;
   logic [31:0]   in_range = '0;
   logic          health_ok = 1'b0;
   logic          flush = 1'b0;
   logic          rd_req = 1'b0;
   logic          rd_sel = 1'b0;
   logic          rd_ack;
   logic [31:0]   rd_data;
   logic          rd_err;
   logic [LW-1:0] level;
   logic          full, empty, overflow, dup_fail;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   trng_read_buffer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_raw(in_raw),
      .in_range(in_range), .health_ok(health_ok), .flush(flush),
      .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_data(rd_data),
      .rd_err(rd_err), .level(level), .full(full), .empty(empty),
      .overflow(overflow), .dup_fail(dup_fail), .dbg_state(dbg_state)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // The queue is the FIFO; m_mode is the read transaction phase
   // (0 no read, 1 waiting for data, 2 acknowledging).
   logic [63:0] exp_q[$];
   int          m_mode = 0;
   int          m_wcnt = 0;
   bit          m_sel = 0;
   logic [31:0] m_data = '0;
   bit          m_err = 0, m_ack = 0, m_ovf = 0, m_dup = 0, m_refv = 0;
   logic [31:0] m_ref = '0;

   always @(posedge clk or negedge aresetn) begin : model
      bit          popping, psel, tmo, have, room;
      logic [63:0] front;
      if (!aresetn) begin
         exp_q.delete();
         m_mode = 0; m_wcnt = 0; m_sel = 0; m_data = '0; m_err = 0; m_ack = 0;
         m_ovf = 0; m_dup = 0; m_refv = 0; m_ref = '0;
      end else begin
         popping = 0; psel = 0; tmo = 0;
         have = (exp_q.size() != 0) && !flush;
         if (m_mode == 2) m_mode = 0;
         else if (m_mode == 0) begin
            if (rd_req) begin
               if (have) begin popping = 1; psel = rd_sel; end
               else begin m_mode = 1; m_wcnt = 0; m_sel = rd_sel; end
            end
         end else begin
            if (have) begin popping = 1; psel = m_sel; end
            else if (TIMEOUT != 0 && m_wcnt == TIMEOUT - 1) tmo = 1;
            else m_wcnt++;
         end
         if (popping || tmo) m_mode = 2;
         if (tmo) begin m_data = '0; m_err = 1; end
         if (flush) begin
            exp_q.delete(); m_ovf = 0; m_dup = 0; m_refv = 0;
         end else begin
            if (popping) begin
               front = exp_q.pop_front();
               m_data = psel ? front[63:32] : front[31:0];
               m_err = 0;
            end
            if (in_valid && health_ok) begin
               room = exp_q.size() < DEPTH;
               if (!room) m_ovf = 1;
               if (DUP_EN && m_refv && in_raw == m_ref) m_dup = 1;
               else if (room) begin
                  exp_q.push_back({in_range, in_raw});
                  m_ref = in_raw; m_refv = 1;
               end
            end
         end
         m_ack = (m_mode == 2);
      end
   end

   // scoreboard compare, away from the active edge
   always @(negedge clk) begin
      if (aresetn) begin
         check("level", level, exp_q.size());
         check("full", full, exp_q.size() == DEPTH);
         check("empty", empty, exp_q.size() == 0);
         check("overflow", overflow, m_ovf);
         check("dup_fail", dup_fail, m_dup);
         check("rd_ack", rd_ack, m_ack);
         if (m_ack) begin
            check("rd_data", rd_data, m_data);
            check("rd_err", rd_err, m_err);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_word(input logic [31:0] raw, input logic [31:0] rng);
      in_valid = 1'b1; in_raw = raw; in_range = rng;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_ack(input int lat0, output int lat);
      lat = lat0;
      while (rd_ack !== 1'b1 && lat < 200) begin
         @(posedge clk); @(negedge clk); lat++;
      end
      check("ack_seen", rd_ack, 1'b1);
   endtask

   task automatic do_read(input bit sel, output logic [31:0] d, output logic e,
                          output int lat, output int lvl);
      rd_req = 1'b1; rd_sel = sel;
      @(posedge clk); @(negedge clk);
      rd_req = 1'b0;
      wait_ack(0, lat);
      d = rd_data; e = rd_err; lvl = int'(level);
      @(negedge clk);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      logic [31:0] d;
      logic        e;
      int          lat, lvl, acks;
      logic [31:0] last_raw;

      repeat (3) @(negedge clk);
      check("rst_rd_ack", rd_ack, 0);
      check("rst_rd_err", rd_err, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_level", level, 0);
      check("rst_full", full, 0);
      check("rst_empty", empty, 1);
      check("rst_overflow", overflow, 0);
      check("rst_dup_fail", dup_fail, 0);
      check("rst_state", dbg_state, 0);
      aresetn = 1'b1;
      health_ok = 1'b1;
      @(negedge clk);

      // basic push / read with half select
      push_word(32'hA5A50001, 32'h10);
      push_word(32'hA5A50002, 32'h11);
      push_word(32'hA5A50003, 32'h12);
      check("basic_level3", level, 3);
      do_read(1'b0, d, e, lat, lvl);
      check("basic_d0", d, 32'hA5A50001); check("basic_lat0", lat, 0); check("basic_lvl2", lvl, 2);
      do_read(1'b1, d, e, lat, lvl);
      check("basic_d1", d, 32'h11); check("basic_lat1", lat, 0); check("basic_lvl1", lvl, 1);
      do_read(1'b0, d, e, lat, lvl);
      check("basic_d2", d, 32'hA5A50003); check("basic_lat2", lat, 0); check("basic_lvl0", lvl, 0);

      // empty read times out
      do_read(1'b0, d, e, lat, lvl);
      check("tmo_lat", lat, TIMEOUT); check("tmo_err", e, 1); check("tmo_data", d, 0);

      // empty read served by a push at e+5
      rd_req = 1'b1; rd_sel = 1'b0;
      @(posedge clk); @(negedge clk);
      rd_req = 1'b0;
      repeat (4) begin @(posedge clk); @(negedge clk); end
      in_valid = 1'b1; in_raw = 32'h12345678; in_range = 32'h9;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      wait_ack(5, lat);
      check("late_lat", lat, 6); check("late_err", rd_err, 0); check("late_data", rd_data, 32'h12345678);
      @(negedge clk);

      // overflow on a full FIFO, then in-order drain
      for (int i = 1; i <= 10; i++) push_word(32'h100 + i, 32'h200 + i);
      check("ovf_level", level, 8); check("ovf_full", full, 1); check("ovf_flag", overflow, 1);
      for (int i = 1; i <= 8; i++) begin
         do_read(1'b0, d, e, lat, lvl);
         check("drain_data", d, 32'h100 + i);
      end

      // health gating
      health_ok = 1'b0;
      for (int i = 0; i < 4; i++) push_word(32'h300 + i, 32'h400 + i);
      check("hlth_level0", level, 0);
      health_ok = 1'b1;
      push_word(32'h304, 32'h404);
      push_word(32'h305, 32'h405);
      check("hlth_level2", level, 2);

      // full with simultaneous push and read, then flush with read waiting
      for (int i = 6; i < 12; i++) push_word(32'h300 + i, 32'h400 + i);
      check("fp_full", full, 1);
      rd_req = 1'b1; rd_sel = 1'b0; in_valid = 1'b1; in_raw = 32'h30C; in_range = 32'h40C;
      @(posedge clk); @(negedge clk);
      rd_req = 1'b0; in_valid = 1'b0;
      check("fp_ack", rd_ack, 1); check("fp_data", rd_data, 32'h304); check("fp_level", level, 8);
      check("fp_ovf_before", overflow, 1);
      @(negedge clk);
      rd_req = 1'b1; flush = 1'b1;
      @(posedge clk); @(negedge clk);
      rd_req = 1'b0;
      check("fl_level", level, 0); check("fl_ovf", overflow, 0); check("fl_state_wait", dbg_state, 1);
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      wait_ack(1, lat);
      check("fl_tmo_lat", lat, TIMEOUT); check("fl_tmo_err", rd_err, 1); check("fl_tmo_data", rd_data, 0);
      @(negedge clk);

      // repeated word
      push_word(32'hDEADBEEF, 32'h1);
      push_word(32'hDEADBEEF, 32'h2);
      check("dup_level", level, DUP_EN ? 1 : 2);
      check("dup_flag", dup_fail, DUP_EN);
      flush = 1'b1;
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      check("dup_flush_flag", dup_fail, 0); check("dup_flush_level", level, 0);

      // reset during a waiting read abandons it
      rd_req = 1'b1;
      @(posedge clk); @(negedge clk);
      rd_req = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      #2 aresetn = 1'b0;
      @(negedge clk);
      check("mid_rst_state", dbg_state, 0); check("mid_rst_ack", rd_ack, 0);
      #2 aresetn = 1'b1;
      acks = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rd_ack) acks++;
      end
      check("mid_rst_no_ack", acks, 0);

      // randomized traffic
      last_raw = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 99) < ((c < 1500) ? 60 : 20));
         health_ok = ($urandom_range(0, 99) < 90);
         flush     = ($urandom_range(0, 99) < 2);
         rd_req    = ($urandom_range(0, 99) < 35);
         rd_sel    = $urandom_range(0, 1);
         in_raw    = ($urandom_range(0, 7) == 0) ? last_raw : $urandom;
         in_range  = $urandom;
         last_raw  = in_raw;
         @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0; flush = 1'b0; rd_req = 1'b0;
      repeat (TIMEOUT + 4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trng_read_buffer.md
# trng_read_buffer

Consumer-side buffer for `trng_core` output. It captures each single-cycle `valid` strobe carrying `random_raw` and `random_in_range` into a small FIFO, gated by `health_ok`. It serves words to the AXI register file through a request/acknowledge read port with a bounded wait and timeout. It absorbs the core's no-backpressure output and reports overflow and, optionally, repeated-word failures.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 4096: maximum wait for data on an empty-FIFO read; 0 means wait forever.
- `clk`  in  1  clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  single-cycle word strobe from the core.
- `in_raw`  in  32  raw random word.
- `in_range`  in  32  range-mapped word.
- `health_ok`  in  1  core health status; words are written only while high.
- `flush`  in  1  synchronous FIFO clear; also clears sticky flags.
- `rd_req`  in  1  read request; sampled only in IDLE.
- `rd_sel`  in  1  0 selects raw, 1 selects range; sampled with `rd_req`.
- `rd_ack`  out  1  one-cycle read completion.
- `rd_data`  out  32  read word; valid while `rd_ack`=1.
- `rd_err`  out  1  timeout indication; valid while `rd_ack`=1.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `full`, `empty`  out  1  occupancy flags.
- `overflow`  out  1  sticky; set when a word is dropped because the FIFO is full.
- `dup_fail`  out  1  sticky; set when the duplicate check rejects a word.

## Operation
- FIFO entry is 64 bits: {`in_range`, `in_raw`}. Read and write pointers carry one wrap bit; `level` = wr − rd.
- Write condition: `in_valid` & `health_ok` & !`flush` & (!`full` | pop this cycle) & dup check passes.
- Drop on full:
  - `in_valid` & `health_ok` with `full` and no pop → word dropped, `overflow` ← 1.
  - Push and pop in the same cycle while full → both proceed; `level` unchanged.
- `flush` has priority over push and pop:
  - Pointers reset; `level` ← 0.
  - `overflow` and `dup_fail` ← 0.
  - A pop scheduled in the same cycle is suppressed.
- FSM states:
  - IDLE:
    - `rd_req` & !`empty` & !`flush` → pop, latch the selected half into `rd_data`, `rd_err` ← 0, go to ACK.
    - `rd_req` otherwise → go to WAIT, timer ← 0, latch `rd_sel`.
  - WAIT:
    - !`empty` & !`flush` → pop and go to ACK.
    - Else if `TIMEOUT_CYCLES`≠0 and timer == `TIMEOUT_CYCLES`−1 → ACK with `rd_data` ← 0, `rd_err` ← 1.
    - Else timer increments.
    - Timer width: $clog2(`TIMEOUT_CYCLES`+1).
  - ACK: `rd_ack`=1 for exactly one cycle; `rd_req` is ignored; go to IDLE.
- `rd_req` in WAIT or ACK is ignored and not queued.
- There is no write-to-read bypass; a word written in WAIT is popped on the following edge.

## Timing
- Reset values:
  - `rd_ack`, `rd_err`, `rd_data`, `overflow`, `dup_fail`, `level`, `full` = 0.
  - `empty` = 1.
  - FSM in IDLE; pointers, timer and duplicate reference cleared.
- All outputs are registered.
- Non-empty read: `rd_req` sampled at edge e → `rd_ack` high in the cycle after edge e. Maximum throughput is one read per 2 cycles.
- Empty read with a write at edge w (w ≥ e): pop at edge w+1 → `rd_ack` high in the cycle after edge w+1.
- Timeout: with no writes, `rd_ack`=`rd_err`=1 in the cycle after edge e+`TIMEOUT_CYCLES`.
- Flags update on the same edge as the pointer change.
- Reset mid-read: the transaction is abandoned, with no `rd_ack`.

## Configuration
- `TRNG_RDBUF_DUP_CHECK_EN` defined: continuous random number test.
  - A 32-bit reference register holds the `in_raw` of the last written word, with a ref-valid bit.
  - A candidate with `in_raw` == reference (ref-valid=1) is not written, and `dup_fail` ← 1.
  - The reference updates only on accepted writes; ref-valid is cleared by reset and `flush`.
- Undefined: no comparator or reference registers; `dup_fail` is tied to 0.

## Test plan
- Push raw 0xA5A50001..0xA5A50003 with range 0x10..0x12; read `rd_sel`=0, then 1, then 0 → `rd_data` = 0xA5A50001, 0x11, 0xA5A50003; `level` goes 3→2→1→0; each `rd_ack` comes 1 cycle after its request.
- Empty FIFO, `TIMEOUT_CYCLES`=16, no input: `rd_req` at edge e → `rd_ack`=`rd_err`=1, `rd_data`=0 in the cycle after edge e+16. Repeat with a push at e+5 → `rd_err`=0 and data returned after edge e+6.
- `DEPTH`=8: push 10 distinct words with no reads → `full`=1, `level`=8, `overflow`=1; 8 reads return words 1..8 in order.
- `health_ok`=0 while pushing 4 words → `level` stays 0; `health_ok`=1 → subsequent words accepted.
- Full FIFO with simultaneous push and IDLE read, then `flush` during WAIT → `level` stays 8 on the pop+push; after flush `level`=0 and `overflow`=0, and WAIT continues to timeout.
- With `TRNG_RDBUF_DUP_CHECK_EN`: push 0xDEADBEEF twice → `level`=1, `dup_fail`=1; `flush` → `dup_fail`=0. Without the macro: `level`=2, `dup_fail`=0.
